// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the data-memory load/store stage.
// Rev 1.0
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Unlisted codes (011, 110, 111) fall through to word accesses.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      F3_LW:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: data-memory request/grant/read-valid bus.
// Rev 1.0
`default_nettype none

interface dmem_lsu_if;
  logic        dmem_req;
  logic        dmem_gnt;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_wdata;
  logic        dmem_rvld;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_wen, dmem_mask, dmem_wdata,
    input  dmem_gnt, dmem_rvld, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_wen, dmem_mask, dmem_wdata,
    output dmem_gnt, dmem_rvld, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: store lane mask/data alignment and load extract/sign-extend.
// Rev 1.0
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data_al,
  output logic [31:0] ld_data
);

  lsu_size_e   size;
  logic        ld_unsigned;
  logic [31:0] shifted;

  always_comb begin
    size        = f3_size(funct3);
    ld_unsigned = funct3[2];
    shifted     = ld_word >> {addr_lo, 3'b000};
    st_mask     = MASK_WORD;
    st_data_al  = st_data;
    ld_data     = shifted;
    case (size)
      SZ_BYTE: begin
        st_mask    = MASK_BYTE << addr_lo;
        st_data_al = {4{st_data[7:0]}};
        ld_data    = {{24{shifted[7] & ~ld_unsigned}}, shifted[7:0]};
      end
      SZ_HALF: begin
        st_mask    = MASK_HALF << addr_lo;
        st_data_al = {2{st_data[15:0]}};
        ld_data    = {{16{shifted[15] & ~ld_unsigned}}, shifted[15:0]};
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// dmem_lsu: memory-access stage issuing data-memory requests and producing write-back results.
// Rev 1.0
`default_nettype none

module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_res,
  input  logic [31:0]       i_wdata,
  input  logic [4:0]        i_rd_waddr,
  input  logic              i_rd_wen,
  output logic              o_stall,
  dmem_lsu_if.master        dmem,
  output logic              o_vld,
  output logic              o_mem_reg,
  output logic [31:0]       o_dmem_rdata,
  output logic [31:0]       o_res,
  output logic [4:0]        o_rd_waddr,
  output logic              o_rd_wen,
  output logic              o_trap_misalign,
  output logic              o_trap_bus
);

  lsu_state_e           state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt;
  logic [2:0]           hold_f3;
  logic [31:0]          hold_res;
  logic [31:0]          hold_wdata;
  logic [4:0]           hold_rd;
  logic                 hold_rd_wen;
  logic                 hold_store;

  logic        accept, is_mem, mis, expire;
  logic        done_alu, done_mis, done_st, done_ld, done_to, done_any;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata, al_rdata;

  assign accept = i_vld & (state == ST_IDLE);
  assign is_mem = i_mem_ren | i_mem_wen;
  assign mis    = misaligned(i_funct3, i_res[1:0]);
  assign expire = (cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));

  lsu_align u_align (
    .funct3     (hold_f3),
    .addr_lo    (hold_res[1:0]),
    .st_data    (hold_wdata),
    .ld_word    (dmem.dmem_rdata),
    .st_mask    (al_mask),
    .st_data_al (al_wdata),
    .ld_data    (al_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A grant or read-valid in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    done_alu  = 1'b0;
    done_mis  = 1'b0;
    done_st   = 1'b0;
    done_ld   = 1'b0;
    done_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem)  done_alu  = 1'b1;
          else if (mis) done_mis  = 1'b1;
          else          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) begin
          if (hold_store) begin
            done_st   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RESP;
          end
        end else if (expire) begin
          done_to   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (dmem.dmem_rvld) begin
          done_ld   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (expire) begin
          done_to   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign done_any = done_alu | done_mis | done_st | done_ld | done_to;
  assign o_stall  = (state != ST_IDLE);

  always_comb begin
    dmem.dmem_req   = (state == ST_REQ);
    dmem.dmem_addr  = '0;
    dmem.dmem_wen   = 1'b0;
    dmem.dmem_mask  = '0;
    dmem.dmem_wdata = '0;
    if (state == ST_REQ) begin
      dmem.dmem_addr  = {hold_res[31:2], 2'b00};
      dmem.dmem_wen   = hold_store;
      dmem.dmem_mask  = al_mask;
      dmem.dmem_wdata = al_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt             <= '0;
      hold_f3         <= '0;
      hold_res        <= '0;
      hold_wdata      <= '0;
      hold_rd         <= '0;
      hold_rd_wen     <= 1'b0;
      hold_store      <= 1'b0;
      o_vld           <= 1'b0;
      o_mem_reg       <= 1'b0;
      o_dmem_rdata    <= '0;
      o_res           <= '0;
      o_rd_waddr      <= '0;
      o_rd_wen        <= 1'b0;
      o_trap_misalign <= 1'b0;
      o_trap_bus      <= 1'b0;
    end else begin
      if (accept) begin
        cnt         <= '0;
        hold_f3     <= i_funct3;
        hold_res    <= i_res;
        hold_wdata  <= i_wdata;
        hold_rd     <= i_rd_waddr;
        hold_rd_wen <= i_rd_wen;
        hold_store  <= i_mem_wen;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + TIMEOUT_W'(1);
      end

      o_vld           <= done_any;
      o_trap_misalign <= done_mis;
      o_trap_bus      <= done_to;

      if (done_alu | done_mis) begin
        o_res      <= i_res;
        o_rd_waddr <= i_rd_waddr;
      end else if (done_st | done_ld | done_to) begin
        o_res      <= hold_res;
        o_rd_waddr <= hold_rd;
      end
      if (done_any) begin
        o_rd_wen  <= (done_alu ? i_rd_wen : hold_rd_wen) & ~(done_mis | done_to);
        o_mem_reg <= done_ld;
      end
      if (done_ld) o_dmem_rdata <= al_rdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Memory-access pipeline stage between execute and write-back.
- Issues data-memory requests over a req/gnt + rvld handshake, and stalls upstream while a request is outstanding.
- Aligns store data and byte masks; extracts and sign/zero-extends load data.
- Presents results to write-back: o_mem_reg selects load data over the ALU result.

Parameters:
- TIMEOUT_CYC, 255: cycles allowed in REQ+RESP before a bus-error trap is raised.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYC.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  upstream instruction valid; accepted when i_vld & !o_stall
- i_mem_ren  in  1  instruction is a load
- i_mem_wen  in  1  instruction is a store (never set together with i_mem_ren)
- i_funct3  in  3  load/store size and sign code
- i_res  in  32  ALU result; this is the effective address for loads/stores
- i_wdata  in  32  store data (rs2)
- i_rd_waddr  in  5  destination register
- i_rd_wen  in  1  destination write enable
- o_stall  out  1  upstream must hold; equals (state != IDLE)
- o_dmem_req  out  1  memory request
- i_dmem_gnt  in  1  request accepted this cycle
- o_dmem_addr  out  32  word-aligned address, {i_res[31:2],2'b00}
- o_dmem_wen  out  1  request is a write
- o_dmem_mask  out  4  byte-lane enables
- o_dmem_wdata  out  32  lane-aligned store data
- i_dmem_rvld  in  1  read data valid
- i_dmem_rdata  in  32  read data word
- o_vld  out  1  one-cycle pulse: instruction complete, to write-back
- o_mem_reg  out  1  o_dmem_rdata carries the result
- o_dmem_rdata  out  32  extracted, extended load data
- o_res  out  32  registered ALU result
- o_rd_waddr  out  5  registered destination register
- o_rd_wen  out  1  registered write enable; forced 0 on any trap
- o_trap_misalign  out  1  valid with o_vld: misaligned access
- o_trap_bus  out  1  valid with o_vld: timeout

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; timeout counter 0.
  - Assertion mid-transaction aborts immediately: o_dmem_req falls asynchronously.
  - Any rvld arriving after reset is ignored.
- States IDLE, REQ, RESP; accepted instruction fields are captured into holding registers.
- IDLE, accepted non-memory op:
  - Next cycle o_vld=1, o_mem_reg=0, fields registered.
  - Latency 1 cycle; back-to-back issue allowed every cycle.
- IDLE, accepted memory op, misaligned:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued. Next cycle: o_vld=1, o_trap_misalign=1, o_rd_wen=0.
- IDLE, accepted memory op, aligned: go to REQ.
- REQ:
  - o_dmem_req=1; address, wen, mask and wdata held stable until i_dmem_gnt.
  - On gnt, a store completes: o_vld next cycle, then IDLE.
  - On gnt, a load goes to RESP.
- RESP:
  - Waits for i_dmem_rvld. i_dmem_rvld is ignored in any state other than RESP.
  - On rvld: next cycle o_vld=1, o_mem_reg=1, o_dmem_rdata extended; then IDLE.
- Timeout:
  - Counter increments each cycle in REQ/RESP and clears on entry to REQ.
  - On reaching TIMEOUT_CYC: drop req, o_vld=1 with o_trap_bus=1 and o_rd_wen=0, return to IDLE.
  - If gnt or rvld coincides with expiry, gnt/rvld wins.
- funct3 codes:
  - 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
  - Stores use 000/001/010 only.
  - Codes 011, 110, 111 behave as word.
- Store mask:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves.
- Load extraction: shift the word right by 8*addr[1:0], then extend per funct3.
- Handshake timing:
  - o_vld and o_stall are registered-state derived.
  - o_stall drops in the same cycle o_vld pulses, so a new instruction can be accepted in that cycle.

Decomposition:
- Package lsu_pkg holds the funct3 size/sign constants, the state enum (IDLE/REQ/RESP) and the base mask constants.
- One combinational sub-module, lsu_align: store mask/data alignment and load extract/extend, unit-testable on its own.

Test Plan:
- ALU op, i_res=32'h1234 → o_vld next cycle, o_res=32'h1234, o_mem_reg=0, o_stall never asserted.
- LB at 0x1003, gnt same cycle as req, rvld one cycle later with rdata=32'h80FF_0000 → o_dmem_addr=0x1000, o_dmem_rdata=32'hFFFF_FF80.
- SH at 0x2002, wdata=32'hABCD_1234, gnt delayed 3 cycles → mask=4'b1100, wdata=32'h1234_1234, o_stall high for 4 cycles, fields stable throughout.
- LW at 0x3001 → no o_dmem_req; o_vld with o_trap_misalign=1, o_rd_wen=0.
- LHU, gnt but no rvld for TIMEOUT_CYC cycles → o_trap_bus=1, o_rd_wen=0, state IDLE; a late rvld is ignored.
- Reset asserted in RESP → o_dmem_req/o_vld/o_stall 0 immediately; after release, a new LBU completes normally.
